// File: rtl/exe_writeback.sv
// Execution-result writeback: merges ALU results and LSU load returns onto the
// single register-file write port, buffering colliding ALU results in a small FIFO.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

module exe_writeback #(
  parameter int SID_WIDTH = `SCOREBOARD_SIZE_WIDTH,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_exe_valid_i,
  input  logic [SID_WIDTH-1:0] alu_sid_i,
  input  logic [4:0]           alu_exe_rd_i,
  input  logic [63:0]          alu_exe_rd_value_i,
  input  logic                 lsu_wb_valid_i,
  input  logic [SID_WIDTH-1:0] lsu_sid_i,
  input  logic [4:0]           lsu_rd_i,
  input  logic [63:0]          lsu_rd_value_i,
  output logic                 rf_wen_o,
  output logic [4:0]           rf_waddr_o,
  output logic [63:0]          rf_wdata_o,
  output logic                 sb_release_valid_o,
  output logic [SID_WIDTH-1:0] sb_release_sid_o,
  output logic                 alu_stall_o,
  output logic [CNT_W-1:0]     fifo_count_o,
  output logic                 ovf_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = SID_WIDTH + 5 + 64;

  // Handshake: both producers present single-cycle valid pulses with no ready;
  // the only flow control is alu_stall_o, which the ALU issue stage must honour.

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CNT_W-1:0] count;

  logic           fifo_empty, fifo_full;
  logic           pop, push, push_ok, drop;
  logic           sel_valid;
  logic [EW-1:0]  sel_entry;
  logic [EW-1:0]  alu_entry;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign alu_entry  = {alu_sid_i, alu_exe_rd_i, alu_exe_rd_value_i};

  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    sel_valid = 1'b0;
    sel_entry = '0;
    if (lsu_wb_valid_i) begin
      sel_valid = 1'b1;
      sel_entry = {lsu_sid_i, lsu_rd_i, lsu_rd_value_i};
      push      = alu_exe_valid_i;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_entry = mem[rptr];
      pop       = 1'b1;
      push      = alu_exe_valid_i;
    end else if (alu_exe_valid_i) begin
      sel_valid = 1'b1;
      sel_entry = alu_entry;
    end
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok = push && (!fifo_full || pop);
    drop    = push && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= alu_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ovf_err_o <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
      if (drop) ovf_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_o           <= 1'b0;
      rf_waddr_o         <= '0;
      rf_wdata_o         <= '0;
      sb_release_valid_o <= 1'b0;
      sb_release_sid_o   <= '0;
    end else begin
      rf_wen_o           <= 1'b0;
      sb_release_valid_o <= 1'b0;
      if (sel_valid) begin
        sb_release_valid_o <= 1'b1;
        {sb_release_sid_o, rf_waddr_o, rf_wdata_o} <= sel_entry;
        rf_wen_o <= (sel_entry[68:64] != 5'd0);
      end
    end
  end

  // Two-slot margin: one result already in flight plus the one arriving this cycle.
  assign alu_stall_o  = (count >= CNT_W'(DEPTH - 2));
  assign fifo_count_o = count;

endmodule
